irq_request_ctrl: RTL and testbench

- Interrupt request controller. It is the initiator side of the intr/int_clr handshake consumed by the fetch-stage control unit.
- Synchronizes an external interrupt pin, detects rising edges, and queues requests.
- Raises intr only at a safe fetch boundary, holds it until the fetch CU returns int_clr, then masks further requests until the handler's RTI retires.
- Sits between the top-level irq pin and the fetch CU / writeback retire logic.

---
 rtl/irq_request_ctrl_pkg.sv | 32 +++
 rtl/irq_sync_edge.sv | 36 +++
 rtl/irq_request_ctrl.sv | 122 ++++++++++++
 tb/tb_irq_request_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_request_ctrl_pkg.sv
// irq_request_ctrl_pkg: shared state encoding, default widths and intr/int_clr handshake timing
//
// Handshake between irq_request_ctrl (initiator) and the fetch CU (responder):
//   - intr is a plain flop output. It rises on the clock edge where the controller
//     enters ASSERT. That happens only when stall_in and fetch_busy were both low
//     and int_en was high in the cycle before.
//   - The fetch CU sees intr and drives int_clr high for the cycle in which it
//     accepts the interrupt vector load.
//   - On the edge that samples int_clr=1 while intr is high, intr falls and
//     in_service rises together. int_clr at any other time is ignored.
//   - If int_clr does not come back within ACK_TIMEOUT cycles of intr being high,
//     intr falls, ack_err latches and the request goes back into the pending queue.
//   - in_service stays high until the rti_done pulse for the handler's RTI.
package irq_request_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PEND    = 2'd1;
    localparam logic [1:0] ST_ASSERT  = 2'd2;
    localparam logic [1:0] ST_SERVICE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        PEND    = ST_PEND,
        ASSERT  = ST_ASSERT,
        SERVICE = ST_SERVICE
    } irq_state_e;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int PEND_W_DEF      = 2;
    localparam int ACK_TIMEOUT_DEF = 8;

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: multi-flop synchronizer for an asynchronous pin plus a one-cycle rising-edge pulse
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset (clears every flop)
//   din    asynchronous input pin
//   rise   one-cycle pulse when the synchronized level goes 0 -> 1
module irq_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              last_q;

    if (STAGES < 2) begin : g_chk
        $error("irq_sync_edge: STAGES must be at least 2");
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync   <= '0;
            last_q <= 1'b0;
        end else begin
            sync   <= {sync[STAGES-2:0], din};
            last_q <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~last_q;

endmodule

// File: rtl/irq_request_ctrl.sv
// irq_request_ctrl: queues external interrupt edges and drives the intr/int_clr handshake to the fetch CU
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   irq_in      external interrupt pin (asynchronous, rising-edge)
//   int_en      global interrupt enable
//   stall_in    pipeline stall; blocks raising intr
//   fetch_busy  fetch CU mid multi-cycle sequence; blocks raising intr
//   int_clr     acknowledge from the fetch CU
//   rti_done    one-cycle pulse when an RTI retires
//   intr        registered interrupt request
//   in_service  handler running
//   pend_cnt    saturating count of queued requests
//   irq_lost    sticky: a request was dropped because the queue was full
//   ack_err     sticky: intr timed out without int_clr
module irq_request_ctrl
    import irq_request_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int PEND_W      = PEND_W_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq_in,
    input  logic              int_en,
    input  logic              stall_in,
    input  logic              fetch_busy,
    input  logic              int_clr,
    input  logic              rti_done,
    output logic              intr,
    output logic              in_service,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              irq_lost,
    output logic              ack_err
);

    localparam int              TW     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]   T_LAST = TW'(ACK_TIMEOUT - 1);
    localparam int              SW     = PEND_W + 2;
    localparam logic [SW-1:0]   P_MAX  = SW'((1 << PEND_W) - 1);

    irq_state_e    state, nxt_state;
    logic [TW-1:0] tcnt;
    logic          irq_edge;
    logic          edge_q, requeue, dequeue, timeout;
    logic [SW-1:0] pend_sum;

    irq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (irq_in),
        .rise  (irq_edge)
    );

    // The pending count is computed with two spare bits so that an increment and a
    // decrement in the same cycle cancel before saturation is applied.
    always_comb begin
        nxt_state = state;
        edge_q    = irq_edge;
        requeue   = 1'b0;
        dequeue   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (int_en && (irq_edge || pend_cnt != '0)) begin
                    nxt_state = PEND;
                    // A fresh edge is launched directly; otherwise the oldest queued request is taken.
                    edge_q    = 1'b0;
                    dequeue   = !irq_edge;
                end
            end
            PEND: begin
                if (!int_en) begin
                    nxt_state = IDLE;
                    requeue   = 1'b1;
                end else if (!stall_in && !fetch_busy) begin
                    nxt_state = ASSERT;
                end
            end
            ASSERT: begin
                if (int_clr) begin
                    nxt_state = SERVICE;
                end else if (tcnt == T_LAST) begin
                    nxt_state = IDLE;
                    requeue   = 1'b1;
                    timeout   = 1'b1;
                end
            end
            SERVICE: begin
                if (rti_done) begin
                    nxt_state = (int_en && pend_cnt != '0) ? PEND : IDLE;
                    dequeue   = int_en && pend_cnt != '0;
                end
            end
            default: nxt_state = IDLE;
        endcase
        pend_sum = {2'b00, pend_cnt} + SW'(edge_q) + SW'(requeue) - SW'(dequeue);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tcnt       <= '0;
            intr       <= 1'b0;
            in_service <= 1'b0;
            pend_cnt   <= '0;
            irq_lost   <= 1'b0;
            ack_err    <= 1'b0;
        end else begin
            state      <= nxt_state;
            tcnt       <= (state == ASSERT && nxt_state == ASSERT) ? tcnt + TW'(1) : '0;
            intr       <= nxt_state == ASSERT;
            in_service <= nxt_state == SERVICE;
            pend_cnt   <= (pend_sum > P_MAX) ? P_MAX[PEND_W-1:0] : pend_sum[PEND_W-1:0];
            irq_lost   <= irq_lost | (pend_sum > P_MAX);
            ack_err    <= ack_err | timeout;
        end
    end

endmodule

// File: tb/tb_irq_request_ctrl.sv
// tb_irq_request_ctrl: table vectors, directed corner sequences and a randomized run against a reference model
module tb_irq_request_ctrl;

    localparam int S    = 2;
    localparam int PW   = 2;
    localparam int TO   = 8;
    localparam int PMAX = (1 << PW) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_PEND   = 1;
    localparam int M_ASSERT = 2;
    localparam int M_SVC    = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic irq_in = 1'b0, int_en = 1'b0, stall_in = 1'b0, fetch_busy = 1'b0, int_clr = 1'b0, rti_done = 1'b0;
    logic intr, in_service, irq_lost, ack_err;
    logic [PW-1:0] pend_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    irq_request_ctrl #(.SYNC_STAGES(S), .PEND_W(PW), .ACK_TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .int_en     (int_en),
        .stall_in   (stall_in),
        .fetch_busy (fetch_busy),
        .int_clr    (int_clr),
        .rti_done   (rti_done),
        .intr       (intr),
        .in_service (in_service),
        .pend_cnt   (pend_cnt),
        .irq_lost   (irq_lost),
        .ack_err    (ack_err)
    );

    always #5 clk = ~clk;

    // stim = {irq_in, int_en, stall_in, fetch_busy, int_clr, rti_done}
    // want = {intr, in_service, pend_cnt, irq_lost, ack_err}
    typedef struct {
        logic [5:0]    stim;
        logic [PW+3:0] want;
    } vec_t;

    vec_t tbl[$];

    // reference model state
    int m_ph, m_pend, m_held;
    bit m_lost, m_err;
    bit hist[$];

    function automatic void add(input logic [5:0] stim, input logic [PW+3:0] want);
        vec_t r;
        r.stim = stim;
        r.want = want;
        tbl.push_back(r);
    endfunction

    function automatic logic [PW+3:0] outs();
        return {intr, in_service, pend_cnt, irq_lost, ack_err};
    endfunction

    function automatic logic [PW+3:0] pack(input bit i, input bit s, input int p, input bit l, input bit e);
        return {i, s, PW'(p), l, e};
    endfunction

    task automatic check(input string name, input logic [PW+3:0] act, input logic [PW+3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got intr=%b svc=%b pend=%0d lost=%b err=%b, want intr=%b svc=%b pend=%0d lost=%b err=%b",
                     name, act[PW+3], act[PW+2], act[PW+1:2], act[1], act[0],
                     exp[PW+3], exp[PW+2], exp[PW+1:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] stim);
        {irq_in, int_en, stall_in, fetch_busy, int_clr, rti_done} = stim;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(6'b000000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        int_en = 1'b1;
    endtask

    task automatic pulse();
        irq_in = 1'b1;
        tick();
        irq_in = 1'b0;
        tick();
    endtask

    task automatic enter_service();
        pulse();
        tick();
        tick();
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
    endtask

    task automatic model_init();
        m_ph   = M_IDLE;
        m_pend = 0;
        m_held = 0;
        m_lost = 1'b0;
        m_err  = 1'b0;
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back(1'b0);
    endtask

    // Advances the model by one clock using the inputs currently driven.
    // hist[0] holds irq_in from the previous clock, so the edge seen now is the
    // rise that happened S clocks ago.
    task automatic model_step();
        bit e;
        int up, down;
        e = hist[S-1] && !hist[S];
        hist.push_front(irq_in);
        void'(hist.pop_back());
        up   = e ? 1 : 0;
        down = 0;
        if (m_ph == M_IDLE) begin
            if (int_en && (e || m_pend > 0)) begin
                m_ph = M_PEND;
                up   = 0;
                down = e ? 0 : 1;
            end
        end else if (m_ph == M_PEND) begin
            if (!int_en) begin
                m_ph = M_IDLE;
                up++;
            end else if (!stall_in && !fetch_busy) begin
                m_ph   = M_ASSERT;
                m_held = 1;
            end
        end else if (m_ph == M_ASSERT) begin
            if (int_clr) begin
                m_ph = M_SVC;
            end else if (m_held == TO) begin
                m_ph  = M_IDLE;
                m_err = 1'b1;
                up++;
            end else begin
                m_held++;
            end
        end else if (rti_done) begin
            if (int_en && m_pend > 0) begin
                m_ph = M_PEND;
                down = 1;
            end else begin
                m_ph = M_IDLE;
            end
        end
        m_pend = m_pend + up - down;
        if (m_pend > PMAX) begin
            m_lost = 1'b1;
            m_pend = PMAX;
        end
    endtask

    function automatic logic [PW+3:0] model_out();
        return pack(m_ph == M_ASSERT, m_ph == M_SVC, m_pend, m_lost, m_err);
    endfunction

    initial begin
        int hi;
        // handshake and safe-point rows
        add(6'b110000, pack(0, 0, 0, 0, 0));
        add(6'b010000, pack(0, 0, 0, 0, 0));
        add(6'b010000, pack(0, 0, 0, 0, 0));
        add(6'b010000, pack(1, 0, 0, 0, 0));
        add(6'b010010, pack(0, 1, 0, 0, 0));
        add(6'b010000, pack(0, 1, 0, 0, 0));
        add(6'b010001, pack(0, 0, 0, 0, 0));
        add(6'b010000, pack(0, 0, 0, 0, 0));
        add(6'b110100, pack(0, 0, 0, 0, 0));
        add(6'b010100, pack(0, 0, 0, 0, 0));
        add(6'b010100, pack(0, 0, 0, 0, 0));
        add(6'b010110, pack(0, 0, 0, 0, 0));
        add(6'b010101, pack(0, 0, 0, 0, 0));
        add(6'b011000, pack(0, 0, 0, 0, 0));
        add(6'b011000, pack(0, 0, 0, 0, 0));
        add(6'b011000, pack(0, 0, 0, 0, 0));
        add(6'b010000, pack(1, 0, 0, 0, 0));
        add(6'b010010, pack(0, 1, 0, 0, 0));
        add(6'b010001, pack(0, 0, 0, 0, 0));
        // int_en drop while pending keeps the request
        add(6'b110000, pack(0, 0, 0, 0, 0));
        add(6'b010000, pack(0, 0, 0, 0, 0));
        add(6'b010100, pack(0, 0, 0, 0, 0));
        add(6'b000000, pack(0, 0, 1, 0, 0));
        add(6'b000000, pack(0, 0, 1, 0, 0));
        add(6'b010100, pack(0, 0, 0, 0, 0));
        add(6'b010000, pack(1, 0, 0, 0, 0));
        add(6'b010010, pack(0, 1, 0, 0, 0));
        add(6'b010001, pack(0, 0, 0, 0, 0));

        repeat (2) @(negedge clk);
        check("reset state", outs(), pack(0, 0, 0, 0, 0));
        reset = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].stim);
            tick();
            check($sformatf("table row %0d", i), outs(), tbl[i].want);
        end

        // edge and dequeue in the same cycle at saturation
        do_reset();
        enter_service();
        repeat (3) pulse();
        tick();
        check("sim pre full", outs(), pack(0, 1, 3, 0, 0));
        irq_in = 1'b1;
        tick();
        irq_in = 1'b0;
        tick();
        rti_done = 1'b1;
        tick();
        rti_done = 1'b0;
        check("sim edge+dequeue", outs(), pack(0, 0, 3, 0, 0));
        tick();
        check("sim goes pend", outs(), pack(1, 0, 3, 0, 0));

        // overflow during service, then requeued request re-asserts
        do_reset();
        enter_service();
        repeat (4) pulse();
        tick();
        check("queue overflow", outs(), pack(0, 1, 3, 1, 0));
        rti_done = 1'b1;
        tick();
        rti_done = 1'b0;
        check("rti dequeue", outs(), pack(0, 0, 2, 1, 0));
        tick();
        check("requeue reassert", outs(), pack(1, 0, 2, 1, 0));

        // asynchronous reset while intr=1 and pend_cnt=2
        #2 reset = 1'b1;
        #1 check("async reset mid op", outs(), pack(0, 0, 0, 0, 0));
        @(negedge clk);
        tick();
        reset = 1'b0;
        drive(6'b010000);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post reset idle", outs(), pack(0, 0, 0, 0, 0));
        end

        // acknowledge timeout
        pulse();
        tick();
        tick();
        hi = 0;
        for (int i = 0; i < 20 && intr; i++) begin
            hi++;
            tick();
        end
        check_val("ack high cycles", hi, TO);
        check("ack timeout", outs(), pack(0, 0, 1, 0, 1));
        int_en  = 1'b0;
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        check("late int_clr ignored", outs(), pack(0, 0, 1, 0, 1));
        #2 reset = 1'b1;
        #1 check("async reset clears err", outs(), pack(0, 0, 0, 0, 0));
        @(negedge clk);
        tick();

        // randomized run against the model
        drive(6'b010000);
        reset = 1'b0;
        model_init();
        for (int c = 0; c < 3000; c++) begin
            check("random", outs(), model_out());
            if ($urandom_range(3) == 0) irq_in = ~irq_in;
            if ($urandom_range(15) == 0) int_en = ~int_en;
            stall_in   = $urandom_range(3) == 0;
            fetch_busy = $urandom_range(3) == 0;
            int_clr    = $urandom_range(3) == 0;
            rti_done   = $urandom_range(9) == 0;
            model_step();
            tick();
        end
        check("random final", outs(), model_out());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
